// File: rtl/ahb_copy_engine.sv
// AHB-lite manager performing memory-to-memory element copies on a valid/ready command.
// Constant-fill mode is compiled in only when AHB_COPY_ENGINE_FILL_EN is defined.
`timescale 1ns/1ps
module ahb_copy_engine #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int W_COUNT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [W_ADDR-1:0]  cmd_src,
  input  logic [W_ADDR-1:0]  cmd_dst,
  input  logic [W_COUNT-1:0] cmd_count,
  input  logic [1:0]         cmd_size,
  input  logic               cmd_fill,
  output logic               done,
  output logic               err,
  input  logic               ahblm_hready,
  input  logic               ahblm_hresp,
  output logic [W_ADDR-1:0]  ahblm_haddr,
  output logic               ahblm_hwrite,
  output logic [1:0]         ahblm_htrans,
  output logic [2:0]         ahblm_hsize,
  output logic [2:0]         ahblm_hburst,
  output logic [3:0]         ahblm_hprot,
  output logic               ahblm_hmastlock,
  output logic [W_DATA-1:0]  ahblm_hwdata,
  input  logic [W_DATA-1:0]  ahblm_hrdata
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DRAIN,
    S_ABORT
  } state_t;

  state_t             state, state_nxt;
  logic [W_ADDR-1:0]  src_addr, dst_addr, addr_inc;
  logic [W_COUNT-1:0] remaining;
  logic [1:0]         size, cmd_size_n;
  logic [W_DATA-1:0]  wbuf;
  logic               fill_cmd, fill_mode;
  logic               accept, bus_err, last_elem;

  function automatic logic [W_ADDR-1:0] align(input logic [W_ADDR-1:0] a, input logic [1:0] sz);
    case (sz)
      2'd0:    return a;
      2'd1:    return {a[W_ADDR-1:1], 1'b0};
      default: return {a[W_ADDR-1:2], 2'b00};
    endcase
  endfunction

  // Pick the element from its byte lane and replicate it across the whole bus.
  function automatic logic [W_DATA-1:0] spread(input logic [W_DATA-1:0] word,
                                               input logic [1:0] lane, input logic [1:0] sz);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'd0:    return {4{b}};
      2'd1:    return {2{h}};
      default: return word;
    endcase
  endfunction

`ifdef AHB_COPY_ENGINE_FILL_EN
  logic fill_q;
  assign fill_cmd  = cmd_fill;
  assign fill_mode = fill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      fill_q <= 1'b0;
    else if (accept) fill_q <= cmd_fill;
  end
`else
  logic unused_fill;
  assign unused_fill = cmd_fill;
  assign fill_cmd    = 1'b0;
  assign fill_mode   = 1'b0;
`endif

  assign cmd_ready  = (state == S_IDLE);
  assign accept     = cmd_valid && cmd_ready;
  assign bus_err    = ahblm_hresp && !ahblm_hready;
  assign last_elem  = (remaining == W_COUNT'(1));
  assign cmd_size_n = (cmd_size == 2'd3) ? 2'd2 : cmd_size;
  assign addr_inc   = W_ADDR'(1) << size;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned and infers a latch.
    state_nxt = state;
    case (state)
      S_IDLE:
        if (accept && cmd_count != '0) state_nxt = fill_cmd ? S_WRITE : S_READ;
      S_READ:
        if (bus_err)           state_nxt = S_ABORT;
        else if (ahblm_hready) state_nxt = S_WRITE;
      S_WRITE:
        if (bus_err)           state_nxt = S_ABORT;
        else if (ahblm_hready) state_nxt = last_elem ? S_DRAIN : (fill_mode ? S_WRITE : S_READ);
      S_DRAIN:
        if (bus_err)           state_nxt = S_ABORT;
        else if (ahblm_hready) state_nxt = S_IDLE;
      S_ABORT:
        if (ahblm_hready)      state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Addresses and count advance once the write address phase is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_addr  <= '0;
      dst_addr  <= '0;
      remaining <= '0;
      size      <= 2'd0;
      // NOTE: the data buffer is reset too, since hwdata must read zero out of reset.
      wbuf      <= '0;
    end else if (accept) begin
      size      <= cmd_size_n;
      src_addr  <= fill_cmd ? cmd_src : align(cmd_src, cmd_size_n);
      dst_addr  <= align(cmd_dst, cmd_size_n);
      remaining <= cmd_count;
      if (fill_cmd) wbuf <= spread(W_DATA'(cmd_src), 2'b00, cmd_size_n);
    end else if (state == S_WRITE && ahblm_hready) begin
      dst_addr  <= dst_addr + addr_inc;
      remaining <= remaining - W_COUNT'(1);
      if (!fill_mode) begin
        wbuf     <= spread(ahblm_hrdata, src_addr[1:0], size);
        src_addr <= src_addr + addr_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      done <= (accept && cmd_count == '0) ||
              (ahblm_hready && (state == S_DRAIN || state == S_ABORT));
      err  <= ahblm_hready && (state == S_ABORT);
    end
  end

  assign ahblm_htrans    = (state == S_READ || state == S_WRITE) ? HTRANS_NSEQ : HTRANS_IDLE;
  assign ahblm_hwrite    = (state == S_WRITE);
  assign ahblm_haddr     = (state == S_READ)  ? src_addr :
                           (state == S_WRITE) ? dst_addr : '0;
  assign ahblm_hsize     = {1'b0, size};
  assign ahblm_hburst    = 3'b000;
  assign ahblm_hprot     = 4'b0011;
  assign ahblm_hmastlock = 1'b0;
  assign ahblm_hwdata    = wbuf;

endmodule

// File: doc/ahb_copy_engine.md
# ahb_copy_engine

AHB-lite manager that performs memory-to-memory copies (and optionally constant fills) on command, driving the same AHB-lite fabric the on-chip SRAM subordinates sit on. A simple valid/ready command port supplies source, destination, element count and element size. The engine pipelines one read and one write per element, so a zero-wait-state subordinate sustains one element per two bus cycles. It reports completion, and any bus error, with a single-cycle done pulse.

## Interface
Parameters:
- W_ADDR, 32, address width
- W_DATA, 32, data width; only 32 supported
- W_COUNT, 16, width of element count

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted when cmd_valid && cmd_ready
- cmd_src  in  W_ADDR  source address (fill value in fill mode)
- cmd_dst  in  W_ADDR  destination address
- cmd_count  in  W_COUNT  number of elements
- cmd_size  in  2  element size: 0 byte, 1 halfword, 2 word; 3 treated as 2
- cmd_fill  in  1  fill mode select (see Configuration)
- done  out  1  one-cycle pulse, command finished
- err  out  1  valid with done: command aborted by bus error
- ahblm_hready  in  1  AHB-lite hready
- ahblm_hresp  in  1  AHB-lite hresp
- ahblm_haddr  out  W_ADDR
- ahblm_hwrite  out  1
- ahblm_htrans  out  2  only IDLE (00) and NSEQ (10) are driven
- ahblm_hsize  out  3  {1'b0, cmd_size}
- ahblm_hburst  out  3  constant 000
- ahblm_hprot  out  4  constant 0011
- ahblm_hmastlock  out  1  constant 0
- ahblm_hwdata  out  W_DATA
- ahblm_hrdata  in  W_DATA

## Operation
- Command latched on acceptance; address low bits below the element size are cleared; both addresses increment by 1 << size per element.
- Per-element flow (copy): read aphase -> read dphase overlapped with write aphase -> write dphase overlapped with the next read aphase.
- States:
  - IDLE: cmd_ready=1, htrans=IDLE. Accept with count=0 -> done pulse next cycle, no bus traffic. Accept with count>0 -> READ.
  - READ: NSEQ read at src.
  - WRITE: NSEQ write at dst, read dphase in progress. rdata captured at hready.
  - DRAIN: write dphase of the last element, htrans=IDLE.
  - ABORT: htrans=IDLE, waiting for the error's second cycle.
- Transitions occur only on cycles with hready=1:
  - READ -> WRITE.
  - WRITE -> READ if elements remain, else DRAIN.
  - DRAIN -> IDLE with done.
- Data lanes:
  - The captured element is taken from the rdata lane selected by src[1:0].
  - It is replicated across all lanes: byte ×4, halfword ×2.
  - The result is held in a single data buffer driving hwdata.
- hwdata must remain stable throughout any write dphase stalled by hready=0.
- Bus error: hresp=1 with hready=0 in any state -> ABORT; htrans forced IDLE from the next cycle. ABORT exits on hready=1 to IDLE with done=1, err=1. No further transfers are issued.
- Outputs at reset: cmd_ready=1, done=0, err=0, htrans=00, hwrite=0, haddr=0, hsize=0, hwdata=0.
- Reset asserted mid-command abandons the command immediately; the bus returns to IDLE asynchronously.

## Timing
- Command accepted in cycle 0; first read aphase in cycle 1.
- Zero wait states, copy of N elements: bus occupied cycles 1..2N+1; done in cycle 2N+2.
- Each wait state inserted by the subordinate delays all subsequent events by one cycle.
- cmd_ready deasserts the cycle after acceptance and reasserts in the done cycle; a new command may be accepted in the done cycle.
- done and err are registered outputs.

## Configuration
- AHB_COPY_ENGINE_FILL_EN defined:
  - cmd_fill=1 skips reads; every element is a NSEQ write at dst.
  - Write data is cmd_src[size-width-1:0] replicated across lanes.
  - Writes issue back-to-back, one per cycle.
  - N elements: done in cycle N+2.
- Not defined: cmd_fill is ignored, treated as 0; fill logic is absent.

## Test plan
- Word copy, count=4, src 0x100, dst 0x200, zero-wait subordinate -> reads 0x100..0x10C, writes 0x200..0x20C with matching data; done in cycle 10, err=0.
- Byte copy, count=3, src 0x101, dst 0x203, source word 0xDDCCBBAA at 0x100 -> first write hsize=0 at 0x203, hwdata=0xBBBBBBBB.
- Random hready=0 stalls on every phase -> hwdata and haddr stable during stalls; destination contents are a correct copy.
- hresp error on the second read -> htrans IDLE the following cycle; no write for element 2; done=1, err=1; cmd_ready returns to 1.
- count=0 -> no NSEQ transfers; done pulse in cycle 1. Reset asserted mid-copy -> htrans=00 and cmd_ready=1 immediately.
- With AHB_COPY_ENGINE_FILL_EN: fill, count=4, word size, cmd_src=0xCAFEF00D, dst 0x300 -> four consecutive NSEQ writes of 0xCAFEF00D; done in cycle 6.
